// File: rtl/lcd_host_ctrl.sv
// Host-side partner of the LCD datapath: holds the source image and command script,
// issues the script over cmd/cmd_valid, and captures the LCD write-back for readback.
module lcd_host_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          img_wr,
    input  logic [5:0]    img_addr,
    input  logic [7:0]    img_data,
    input  logic          script_wr,
    input  logic [3:0]    script_data,
    input  logic          script_clr,
    input  logic          start,
    input  logic          IROM_rd,
    input  logic [5:0]    IROM_A,
    output logic [7:0]    IROM_Q,
    output logic [3:0]    cmd,
    output logic          cmd_valid,
    input  logic          busy,
    input  logic          IRAM_valid,
    input  logic [5:0]    IRAM_A,
    input  logic [7:0]    IRAM_D,
    input  logic          done,
    input  logic [5:0]    res_addr,
    output logic [7:0]    res_data,
    output logic          host_done,
    output logic          script_full,
    output logic          load_err,
    output logic          err,
    output logic [15:0]   cyc_cnt
);

    // state | meaning
    // IDLE  | accepts image/script loads, waits for start
    // RUN   | issues script entries whenever busy is low
    // CAPT  | records LCD write-back until done
    // FIN   | run complete, results readable, start reruns
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPT, S_FIN} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t      state, state_nxt;
    logic [7:0]  img_mem [64];
    logic [7:0]  res_mem [64];
    logic [3:0]  script_mem [DEPTH];
    logic [AW:0] script_len;
    logic [AW:0] ptr;
    logic [6:0]  wr_cnt;
    logic [7:0]  wr_total;
    logic        code_ok;

    assign script_full = (script_len == DEPTH_L);
    assign code_ok     = (script_data <= 4'hb);
    assign IROM_Q      = IROM_rd ? img_mem[IROM_A] : 8'h00;
    assign res_data    = res_mem[res_addr];
    // A write landing in the same cycle as done still counts toward the total.
    assign wr_total    = {1'b0, wr_cnt} + {7'd0, IRAM_valid};

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_FIN: if (start) state_nxt = S_RUN;
            S_RUN:         if (cmd_valid && cmd == 4'h0) state_nxt = S_CAPT;
            S_CAPT:        if (done) state_nxt = S_FIN;
            default:       state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = 1'b0;
        cmd       = 4'h0;
        if (state == S_RUN && !busy) begin
            cmd_valid = 1'b1;
            if (ptr < script_len)
                cmd = script_mem[ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && img_wr)
            img_mem[img_addr] <= img_data;
        if (state == S_IDLE && script_wr && !script_clr && !script_full && code_ok)
            script_mem[script_len[AW-1:0]] <= script_data;
        if (state == S_CAPT && IRAM_valid)
            res_mem[IRAM_A] <= IRAM_D;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            script_len <= '0;
            wr_cnt     <= '0;
            cyc_cnt    <= '0;
            host_done  <= 1'b0;
            load_err   <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                if (script_clr)
                    script_len <= '0;
                else if (script_wr) begin
                    if (!code_ok)
                        load_err <= 1'b1;
                    else if (!script_full)
                        script_len <= script_len + 1'b1;
                end
            end
            if ((state == S_IDLE || state == S_FIN) && start) begin
                ptr       <= '0;
                wr_cnt    <= '0;
                cyc_cnt   <= '0;
                host_done <= 1'b0;
                err       <= 1'b0;
            end
            if (state == S_RUN || state == S_CAPT) begin
                if (cyc_cnt != 16'hFFFF)
                    cyc_cnt <= cyc_cnt + 16'd1;
            end
            if (state == S_RUN && cmd_valid)
                ptr <= ptr + 1'b1;
            if (state == S_CAPT) begin
                if (IRAM_valid)
                    wr_cnt <= wr_cnt + 7'd1;
                if (done) begin
                    host_done <= 1'b1;
                    if (wr_total != 8'd64)
                        err <= 1'b1;
                end
            end
            // Stray writes outside capture are flagged; this wins over a same-cycle start clear.
            if (state != S_CAPT && IRAM_valid)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_host_ctrl.sv
// Directed bench for lcd_host_ctrl; the bench plays the LCD side (issue handshake,
// image read, write-back) and checks against hand-derived values.
module tb_lcd_host_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        img_wr = 1'b0;
    logic [5:0]  img_addr = '0;
    logic [7:0]  img_data = '0;
    logic        script_wr = 1'b0;
    logic [3:0]  script_data = '0;
    logic        script_clr = 1'b0;
    logic        start = 1'b0;
    logic        IROM_rd = 1'b0;
    logic [5:0]  IROM_A = '0;
    logic [7:0]  IROM_Q;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic        busy = 1'b1;
    logic        IRAM_valid = 1'b0;
    logic [5:0]  IRAM_A = '0;
    logic [7:0]  IRAM_D = '0;
    logic        done = 1'b0;
    logic [5:0]  res_addr = '0;
    logic [7:0]  res_data;
    logic        host_done;
    logic        script_full;
    logic        load_err;
    logic        err;
    logic [15:0] cyc_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] lcd_buf [64];
    logic [3:0] cmds [32];
    int         pulses;
    int         viol;
    bit         got0;

    lcd_host_ctrl #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .reset(reset),
        .img_wr(img_wr), .img_addr(img_addr), .img_data(img_data),
        .script_wr(script_wr), .script_data(script_data), .script_clr(script_clr),
        .start(start),
        .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IROM_Q(IROM_Q),
        .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
        .IRAM_valid(IRAM_valid), .IRAM_A(IRAM_A), .IRAM_D(IRAM_D), .done(done),
        .res_addr(res_addr), .res_data(res_data),
        .host_done(host_done), .script_full(script_full),
        .load_err(load_err), .err(err), .cyc_cnt(cyc_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic img_load(input int a, input logic [7:0] v);
        img_wr = 1'b1; img_addr = 6'(a); img_data = v;
        step();
        img_wr = 1'b0;
    endtask

    task automatic script_push(input logic [3:0] code);
        script_wr = 1'b1; script_data = code;
        step();
        script_wr = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // mode 0: busy always low; mode 1: busy low one cycle in three
    task automatic drive_issue(input int mode);
        pulses = 0; viol = 0; got0 = 1'b0;
        for (int idx = 0; idx < 60 && !got0; idx++) begin
            busy = (mode == 1) ? (idx % 3 != 2) : 1'b0;
            #1;
            if (cmd_valid) begin
                if (busy) viol++;
                if (pulses < 32) cmds[pulses] = cmd;
                pulses++;
                if (cmd == 4'h0) got0 = 1'b1;
            end else if (cmd !== 4'h0) begin
                viol++;
            end
            step();
        end
        busy = 1'b0;
        #1;
        if (cmd_valid) pulses++;
        step();
        busy = 1'b1;
    endtask

    task automatic lcd_read_image();
        for (int i = 0; i < 64; i++) begin
            IROM_rd = 1'b1; IROM_A = 6'(i);
            #1;
            lcd_buf[i] = IROM_Q;
            step();
        end
        IROM_rd = 1'b0;
    endtask

    task automatic lcd_write_back(input int n, input bit with_done);
        for (int i = 0; i < n; i++) begin
            IRAM_valid = 1'b1; IRAM_A = 6'(i); IRAM_D = lcd_buf[i];
            done = with_done && (i == n - 1);
            step();
        end
        IRAM_valid = 1'b0;
        done = 1'b0;
        if (!with_done) begin
            done = 1'b1;
            step();
            done = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        busy = 1'b0;
        #1;
        n_tests++;
        if (cmd_valid !== 1'b0 || cmd !== 4'h0) begin
            n_fail++; $display("FAIL reset_cmd: cmd_valid=%b cmd=%h, want 0 0", cmd_valid, cmd);
        end
        n_tests++;
        if (host_done !== 1'b0 || err !== 1'b0 || load_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: host_done=%b err=%b load_err=%b, want 0", host_done, err, load_err);
        end
        n_tests++;
        if (cyc_cnt !== 16'd0 || script_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_cnt: cyc_cnt=%0d script_full=%b, want 0 0", cyc_cnt, script_full);
        end
        n_tests++;
        if (IROM_Q !== 8'h00) begin
            n_fail++; $display("FAIL irom_idle: IROM_Q=%h, want 00", IROM_Q);
        end
        busy = 1'b1;
        step();
    endtask

    task automatic test_copy();
        for (int i = 0; i < 64; i++) img_load(i, 8'(i));
        script_push(4'h0);
        start_run();
        drive_issue(0);
        n_tests++;
        if (pulses != 1 || cmds[0] !== 4'h0 || viol != 0) begin
            n_fail++; $display("FAIL copy_issue: pulses=%0d cmd=%h viol=%0d, want 1 0 0", pulses, cmds[0], viol);
        end
        lcd_read_image();
        for (int i = 0; i < 64; i++) begin
            n_tests++;
            if (lcd_buf[i] !== 8'(i)) begin
                n_fail++; $display("FAIL copy_irom[%0d]: got %h, want %h", i, lcd_buf[i], 8'(i));
            end
        end
        lcd_write_back(64, 1'b0);
        n_tests++;
        if (host_done !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL copy_done: host_done=%b err=%b, want 1 0", host_done, err);
        end
        n_tests++;
        if (cyc_cnt !== 16'd131) begin
            n_fail++; $display("FAIL copy_cyc: cyc_cnt=%0d, want 131", cyc_cnt);
        end
        for (int i = 0; i < 64; i++) begin
            res_addr = 6'(i);
            #1;
            n_tests++;
            if (res_data !== 8'(i)) begin
                n_fail++; $display("FAIL copy_res[%0d]: got %h, want %h", i, res_data, 8'(i));
            end
        end
        step();
    endtask

    task automatic test_max_busy();
        logic [7:0] mx;
        logic [7:0] want;
        do_reset();
        script_push(4'h5);
        script_push(4'h0);
        start_run();
        drive_issue(1);
        n_tests++;
        if (pulses != 2 || viol != 0) begin
            n_fail++; $display("FAIL max_pulses: pulses=%0d viol=%0d, want 2 0", pulses, viol);
        end
        n_tests++;
        if (cmds[0] !== 4'h5 || cmds[1] !== 4'h0) begin
            n_fail++; $display("FAIL max_cmds: got %h %h, want 5 0", cmds[0], cmds[1]);
        end
        lcd_read_image();
        mx = lcd_buf[27];
        if (lcd_buf[28] > mx) mx = lcd_buf[28];
        if (lcd_buf[35] > mx) mx = lcd_buf[35];
        if (lcd_buf[36] > mx) mx = lcd_buf[36];
        lcd_buf[27] = mx; lcd_buf[28] = mx; lcd_buf[35] = mx; lcd_buf[36] = mx;
        lcd_write_back(64, 1'b0);
        for (int i = 0; i < 64; i++) begin
            res_addr = 6'(i);
            want = (i == 27 || i == 28 || i == 35 || i == 36) ? 8'd36 : 8'(i);
            #1;
            n_tests++;
            if (res_data !== want) begin
                n_fail++; $display("FAIL max_res[%0d]: got %h, want %h", i, res_data, want);
            end
        end
        n_tests++;
        if (host_done !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL max_done: host_done=%b err=%b, want 1 0", host_done, err);
        end
        step();
    endtask

    task automatic test_empty_script();
        do_reset();
        for (int i = 0; i < 64; i++) img_load(i, 8'(i * 3 + 1));
        start_run();
        drive_issue(0);
        n_tests++;
        if (pulses != 1 || cmds[0] !== 4'h0) begin
            n_fail++; $display("FAIL empty_issue: pulses=%0d cmd=%h, want 1 0", pulses, cmds[0]);
        end
        lcd_read_image();
        lcd_write_back(64, 1'b0);
        for (int i = 0; i < 64; i++) begin
            res_addr = 6'(i);
            #1;
            n_tests++;
            if (res_data !== 8'(i * 3 + 1)) begin
                n_fail++; $display("FAIL empty_res[%0d]: got %h, want %h", i, res_data, 8'(i * 3 + 1));
            end
        end
        n_tests++;
        if (host_done !== 1'b1) begin
            n_fail++; $display("FAIL empty_done: host_done=%b, want 1", host_done);
        end
        step();
    endtask

    task automatic test_script_full();
        do_reset();
        for (int i = 0; i < 15; i++) script_push(4'h1);
        n_tests++;
        if (script_full !== 1'b0) begin
            n_fail++; $display("FAIL full_15: script_full=%b, want 0", script_full);
        end
        script_push(4'h1);
        script_push(4'h1);
        n_tests++;
        if (script_full !== 1'b1 || load_err !== 1'b0) begin
            n_fail++; $display("FAIL full_17: script_full=%b load_err=%b, want 1 0", script_full, load_err);
        end
        script_push(4'hd);
        n_tests++;
        if (load_err !== 1'b1 || script_full !== 1'b1) begin
            n_fail++; $display("FAIL full_bad_code: load_err=%b script_full=%b, want 1 1", load_err, script_full);
        end
        start_run();
        drive_issue(0);
        n_tests++;
        if (pulses != 17 || cmds[0] !== 4'h1 || cmds[15] !== 4'h1 || cmds[16] !== 4'h0) begin
            n_fail++; $display("FAIL full_issue: pulses=%0d c0=%h c15=%h c16=%h, want 17 1 1 0",
                               pulses, cmds[0], cmds[15], cmds[16]);
        end
    endtask

    task automatic test_reset_mid_capt();
        IRAM_valid = 1'b1; IRAM_A = 6'd0; IRAM_D = 8'h11;
        step();
        IRAM_valid = 1'b0;
        do_reset();
        busy = 1'b0;
        #1;
        n_tests++;
        if (cmd_valid !== 1'b0 || host_done !== 1'b0 || cyc_cnt !== 16'd0) begin
            n_fail++; $display("FAIL rst_capt: cmd_valid=%b host_done=%b cyc_cnt=%0d, want 0 0 0",
                               cmd_valid, host_done, cyc_cnt);
        end
        n_tests++;
        if (script_full !== 1'b0 || load_err !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL rst_capt_flags: script_full=%b load_err=%b err=%b, want 0",
                               script_full, load_err, err);
        end
        busy = 1'b1;
        start_run();
        drive_issue(0);
        n_tests++;
        if (pulses != 1 || cmds[0] !== 4'h0) begin
            n_fail++; $display("FAIL rst_len: pulses=%0d cmd=%h, want 1 0", pulses, cmds[0]);
        end
    endtask

    task automatic test_ignored_in_run();
        do_reset();
        for (int i = 0; i < 64; i++) img_load(i, 8'(i));
        script_push(4'h0);
        start_run();
        busy = 1'b1;
        img_wr = 1'b1; img_addr = 6'd5; img_data = 8'hAA; start = 1'b1;
        step();
        img_wr = 1'b0; start = 1'b0;
        drive_issue(0);
        n_tests++;
        if (pulses != 1 || cmds[0] !== 4'h0) begin
            n_fail++; $display("FAIL run_issue: pulses=%0d cmd=%h, want 1 0", pulses, cmds[0]);
        end
        lcd_read_image();
        n_tests++;
        if (lcd_buf[5] !== 8'h05) begin
            n_fail++; $display("FAIL run_img5: got %h, want 05", lcd_buf[5]);
        end
        lcd_write_back(64, 1'b0);
        n_tests++;
        if (cyc_cnt !== 16'd132 || host_done !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL run_end: cyc_cnt=%0d host_done=%b err=%b, want 132 1 0",
                               cyc_cnt, host_done, err);
        end
        res_addr = 6'd5;
        #1;
        n_tests++;
        if (res_data !== 8'h05) begin
            n_fail++; $display("FAIL run_res5: got %h, want 05", res_data);
        end
        step();
    endtask

    task automatic test_back_to_back();
        IRAM_valid = 1'b1; IRAM_A = 6'd1; IRAM_D = 8'h77;
        step();
        IRAM_valid = 1'b0;
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL stray_write: err=%b, want 1", err);
        end
        res_addr = 6'd1;
        #1;
        n_tests++;
        if (res_data !== 8'h01) begin
            n_fail++; $display("FAIL stray_res1: got %h, want 01", res_data);
        end
        step();
        start_run();
        n_tests++;
        if (err !== 1'b0 || host_done !== 1'b0) begin
            n_fail++; $display("FAIL rerun_clear: err=%b host_done=%b, want 0 0", err, host_done);
        end
        drive_issue(0);
        lcd_read_image();
        lcd_write_back(63, 1'b0);
        n_tests++;
        if (err !== 1'b1 || host_done !== 1'b1) begin
            n_fail++; $display("FAIL short_capt: err=%b host_done=%b, want 1 1", err, host_done);
        end
        start_run();
        drive_issue(0);
        n_tests++;
        if (pulses != 1 || cmds[0] !== 4'h0) begin
            n_fail++; $display("FAIL rerun_issue: pulses=%0d cmd=%h, want 1 0", pulses, cmds[0]);
        end
        lcd_read_image();
        lcd_buf[63] = 8'hC3;
        lcd_write_back(64, 1'b1);
        n_tests++;
        if (err !== 1'b0 || host_done !== 1'b1) begin
            n_fail++; $display("FAIL same_cycle_done: err=%b host_done=%b, want 0 1", err, host_done);
        end
        res_addr = 6'd63;
        #1;
        n_tests++;
        if (res_data !== 8'hC3) begin
            n_fail++; $display("FAIL last_write: res[63]=%h, want c3", res_data);
        end
        step();
    endtask

    initial begin
        step();
        step();
        test_reset();
        test_copy();
        test_max_busy();
        test_empty_script();
        test_script_full();
        test_reset_mid_capt();
        test_ignored_in_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
